// File: rtl/isa_pkg.sv
// ---------------------------------------------------------------------------
// isa_pkg
// Shared ISA definitions for the decode stage: opcode encoding, instruction
// field positions, default widths and the control-decode helper.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package isa_pkg;

  localparam int WIDTH_DEF = 24;
  localparam int NREG_DEF  = 16;
  localparam int REG_IDX_W = 4;

  // Instruction field bit positions
  localparam int OP_HI  = 23;
  localparam int OP_LO  = 20;
  localparam int RD_HI  = 19;
  localparam int RD_LO  = 16;
  localparam int RS1_HI = 15;
  localparam int RS1_LO = 12;
  localparam int RS2_HI = 11;
  localparam int RS2_LO = 8;
  localparam int IMM_HI = 11;
  localparam int IMM_LO = 0;
  localparam int IMM_W  = IMM_HI - IMM_LO + 1;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_ADDI  = 4'd5,
    OP_LOAD  = 4'd6,
    OP_STORE = 4'd7,
    OP_BEQ   = 4'd8,
    OP_JMP   = 4'd9
  } opcode_e;

  // Decoded control: effective opcode plus which source fields are live.
  typedef struct packed {
    logic [3:0] op_eff;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       use_rs1;
    logic       use_b;
    logic       b_is_rd;
  } ctrl_t;

  // Undefined opcodes collapse to NOP so they carry no side effects.
  function automatic ctrl_t decode_ctrl(input logic [3:0] op);
    ctrl_t c;
    c = '0;
    c.op_eff = op;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        c.regwrite = 1'b1;
        c.use_rs1  = 1'b1;
        c.use_b    = 1'b1;
      end
      OP_ADDI: begin
        c.regwrite = 1'b1;
        c.use_rs1  = 1'b1;
      end
      OP_LOAD: begin
        c.regwrite = 1'b1;
        c.memread  = 1'b1;
        c.use_rs1  = 1'b1;
      end
      OP_STORE: begin
        c.memwrite = 1'b1;
        c.use_rs1  = 1'b1;
        c.use_b    = 1'b1;
        c.b_is_rd  = 1'b1;
      end
      OP_BEQ: begin
        c.branch   = 1'b1;
        c.use_rs1  = 1'b1;
        c.use_b    = 1'b1;
        c.b_is_rd  = 1'b1;
      end
      OP_JMP: begin
        c.branch   = 1'b1;
      end
      default: begin
        c.op_eff   = OP_NOP;
      end
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
// NREG x WIDTH register file, two asynchronous read ports, one synchronous
// write port. R0 is hardwired to zero; a same-cycle write is forwarded to
// the read ports.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile
  import isa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREG  = NREG_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] ra,
  input  logic [REG_IDX_W-1:0] rb,
  output logic [WIDTH-1:0]     rdata_a,
  output logic [WIDTH-1:0]     rdata_b,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] wa,
  input  logic [WIDTH-1:0]     wdata
);

  logic [WIDTH-1:0] regs [NREG];

  // Write port; R0 is never written so it always reads back zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wdata;
    end
  end

  // Read port A with write-before-read forwarding.
  always_comb begin
    rdata_a = '0;
    if (ra != '0) begin
      rdata_a = (we && (wa == ra)) ? wdata : regs[ra];
    end
  end

  // Read port B with write-before-read forwarding.
  always_comb begin
    rdata_b = '0;
    if (rb != '0) begin
      rdata_b = (we && (wa == rb)) ? wdata : regs[rb];
    end
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Instruction decode: field extraction, control decode, register read,
// load-use hazard detection and the decode/execute pipeline register.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decode_stage
  import isa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREG  = NREG_DEF
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     instruccion,
  input  logic [WIDTH-1:0]     nextPc,
  input  logic                 if_valid,
  input  logic                 flush,
  input  logic                 wb_we,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [WIDTH-1:0]     wb_data,
  output logic                 stall,
  output logic                 ex_valid,
  output logic [3:0]           ex_op,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [WIDTH-1:0]     ex_a,
  output logic [WIDTH-1:0]     ex_b,
  output logic [WIDTH-1:0]     ex_imm,
  output logic [WIDTH-1:0]     ex_pc,
  output logic                 ex_regwrite,
  output logic                 ex_memread,
  output logic                 ex_memwrite,
  output logic                 ex_branch
);

  logic [3:0]           op;
  logic [REG_IDX_W-1:0] rd;
  logic [REG_IDX_W-1:0] rs1;
  logic [REG_IDX_W-1:0] rs2;
  logic [REG_IDX_W-1:0] b_idx;
  logic [WIDTH-1:0]     imm_sext;
  logic [WIDTH-1:0]     rdata_a;
  logic [WIDTH-1:0]     rdata_b;
  ctrl_t                ctrl;
  logic                 hazard;
  logic                 issue;

  assign op       = instruccion[OP_HI:OP_LO];
  assign rd       = instruccion[RD_HI:RD_LO];
  assign rs1      = instruccion[RS1_HI:RS1_LO];
  assign rs2      = instruccion[RS2_HI:RS2_LO];
  assign imm_sext = {{(WIDTH-IMM_W){instruccion[IMM_HI]}}, instruccion[IMM_HI:IMM_LO]};
  assign ctrl     = decode_ctrl(op);

  // STORE and BEQ compare/store the rd register, so it replaces rs2 on port B.
  assign b_idx    = ctrl.b_is_rd ? rd : rs2;

  regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_regfile (
    .clk     (CLK),
    .rst_n   (rst),
    .ra      (rs1),
    .rb      (b_idx),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (wb_we),
    .wa      (wb_rd),
    .wdata   (wb_data)
  );

  // Load-use hazard: a load in execute targets a source this instruction reads.
  always_comb begin
    hazard = 1'b0;
    if (ex_valid && ex_memread && (ex_rd != '0)) begin
      hazard = (ctrl.use_rs1 && (rs1 == ex_rd)) ||
               (ctrl.use_b   && (b_idx == ex_rd));
    end
  end

  // Flush and empty decode both override the hazard; reset forces stall low.
  assign stall = rst && if_valid && !flush && hazard;
  assign issue = if_valid && !flush && !hazard;

  // Execute pipeline register: decoded instruction or an all-zero bubble.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      ex_valid    <= 1'b0;
      ex_op       <= '0;
      ex_rd       <= '0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
    end else if (issue) begin
      ex_valid    <= 1'b1;
      ex_op       <= ctrl.op_eff;
      ex_rd       <= rd;
      ex_a        <= rdata_a;
      ex_b        <= rdata_b;
      ex_imm      <= imm_sext;
      ex_pc       <= nextPc;
      ex_regwrite <= ctrl.regwrite;
      ex_memread  <= ctrl.memread;
      ex_memwrite <= ctrl.memwrite;
      ex_branch   <= ctrl.branch;
    end else begin
      ex_valid    <= 1'b0;
      ex_op       <= '0;
      ex_rd       <= '0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
// Self-checking bench for decode_stage: behavioural pipeline model checked
// every cycle, plus directed scenarios with literal expectations.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_decode_stage;

  typedef struct packed {
    logic        v;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] imm;
    logic [23:0] pc;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
  } ex_t;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] instruccion = 24'h642000;
  logic [23:0] nextPc = 24'h000777;
  logic        if_valid = 1'b1;
  logic        flush = 1'b0;
  logic        wb_we = 1'b1;
  logic [3:0]  wb_rd = 4'd5;
  logic [23:0] wb_data = 24'hFFFFFF;

  logic        stall;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [3:0]  ex_rd;
  logic [23:0] ex_a;
  logic [23:0] ex_b;
  logic [23:0] ex_imm;
  logic [23:0] ex_pc;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_branch;

  int n_pass  = 0;
  int n_total = 0;

  decode_stage dut (
    .CLK         (CLK),
    .rst         (rst),
    .instruccion (instruccion),
    .nextPc      (nextPc),
    .if_valid    (if_valid),
    .flush       (flush),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .ex_op       (ex_op),
    .ex_rd       (ex_rd),
    .ex_a        (ex_a),
    .ex_b        (ex_b),
    .ex_imm      (ex_imm),
    .ex_pc       (ex_pc),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_memwrite (ex_memwrite),
    .ex_branch   (ex_branch)
  );

  always #5 CLK = ~CLK;

  ex_t actual_ex;
  assign actual_ex = {ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_imm, ex_pc,
                      ex_regwrite, ex_memread, ex_memwrite, ex_branch};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  ex_t         m_ex = '0;
  ex_t         m_next;
  logic [23:0] m_regs [16];
  logic [3:0]  m_op;
  logic        m_hz;

  // Does the instruction at the decode inputs read the register a pending load writes?
  function automatic logic m_hazard();
    logic [3:0] op;
    logic [3:0] rdf;
    logic [3:0] r1;
    logic [3:0] r2;
    op  = instruccion[23:20];
    rdf = instruccion[19:16];
    r1  = instruccion[15:12];
    r2  = instruccion[11:8];
    if (!(m_ex.v && m_ex.mr && m_ex.rd != 4'd0)) return 1'b0;
    if (op >= 4'd1 && op <= 4'd8 && r1 == m_ex.rd) return 1'b1;
    if (op >= 4'd1 && op <= 4'd4 && r2 == m_ex.rd) return 1'b1;
    if ((op == 4'd7 || op == 4'd8) && rdf == m_ex.rd) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
  end

  always @(posedge CLK or negedge rst) begin
    if (!rst) begin
      m_ex = '0;
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
    end else begin
      m_hz   = m_hazard();
      m_next = '0;
      // The writeback value is visible to this decode, so commit it first.
      if (wb_we && wb_rd != 4'd0) m_regs[wb_rd] = wb_data;
      if (if_valid && !flush && !m_hz) begin
        m_op        = instruccion[23:20];
        m_next.v    = 1'b1;
        m_next.op   = (m_op <= 4'd9) ? m_op : 4'd0;
        m_next.rd   = instruccion[19:16];
        m_next.a    = m_regs[instruccion[15:12]];
        m_next.b    = (m_op == 4'd7 || m_op == 4'd8) ? m_regs[instruccion[19:16]]
                                                     : m_regs[instruccion[11:8]];
        m_next.imm  = {{12{instruccion[11]}}, instruccion[11:0]};
        m_next.pc   = nextPc;
        m_next.rw   = (m_op >= 4'd1 && m_op <= 4'd6);
        m_next.mr   = (m_op == 4'd6);
        m_next.mw   = (m_op == 4'd7);
        m_next.br   = (m_op == 4'd8 || m_op == 4'd9);
      end
      m_ex = m_next;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    check("model_stall", {127'd0, stall}, {127'd0, rst && if_valid && !flush && m_hazard()});
    check("model_ex", {19'd0, actual_ex}, {19'd0, m_ex});
  end

  // ---------------- directed stimulus ----------------
  logic [23:0] pc_cnt = 24'h000100;

  task automatic drive(input logic [23:0] ins, input logic v, input logic fl,
                       input logic we, input logic [3:0] wr, input logic [23:0] wd);
    @(posedge CLK);
    #2;
    instruccion = ins;
    nextPc      = pc_cnt;
    pc_cnt      = pc_cnt + 24'd1;
    if_valid    = v;
    flush       = fl;
    wb_we       = we;
    wb_rd       = wr;
    wb_data     = wd;
  endtask

  task automatic idle();
    drive(24'h000000, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with live inputs, including a write to R5.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_ex_zero", {19'd0, actual_ex}, 128'd0);
    check("reset_stall", {127'd0, stall}, 128'd0);

    // Release and read R5 (must still be zero).
    @(posedge CLK);
    #2;
    rst = 1'b1;
    instruccion = 24'h165000;  // ADD R6,R5,R0
    nextPc = 24'h000050;
    wb_we = 1'b0;
    idle();
    @(negedge CLK);
    check("r5_after_reset_valid", {127'd0, ex_valid}, 128'd1);
    check("r5_after_reset_a", {104'd0, ex_a}, 128'd0);
    check("first_pc", {104'd0, ex_pc}, 128'h50);

    // Seed R1=0x10, R4=0x400.
    drive(24'h0, 1'b0, 1'b0, 1'b1, 4'd1, 24'h000010);
    drive(24'h0, 1'b0, 1'b0, 1'b1, 4'd4, 24'h000400);

    // ADDI R1,R0,#-3
    drive(24'h510FFD, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0);
    idle();
    @(negedge CLK);
    check("addi_op", {124'd0, ex_op}, 128'd5);
    check("addi_rd", {124'd0, ex_rd}, 128'd1);
    check("addi_a", {104'd0, ex_a}, 128'd0);
    check("addi_imm", {104'd0, ex_imm}, 128'hFFFFFD);
    check("addi_regwrite", {127'd0, ex_regwrite}, 128'd1);

    // Bypass: ADD R3,R2,R2 while R2 is being written.
    drive(24'h132200, 1'b1, 1'b0, 1'b1, 4'd2, 24'h00ABCD);
    idle();
    @(negedge CLK);
    check("bypass_a", {104'd0, ex_a}, 128'h00ABCD);
    check("bypass_b", {104'd0, ex_b}, 128'h00ABCD);

    // Write to R0 is dropped.
    drive(24'h0, 1'b0, 1'b0, 1'b1, 4'd0, 24'h123456);
    drive(24'h110000, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0);
    idle();
    @(negedge CLK);
    check("r0_valid", {127'd0, ex_valid}, 128'd1);
    check("r0_a", {104'd0, ex_a}, 128'd0);
    check("r0_b", {104'd0, ex_b}, 128'd0);

    // Load-use: LOAD R4,[R2] then ADD R5,R4,R1.
    drive(24'h642000, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0);
    drive(24'h154100, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0);
    @(negedge CLK);
    check("loaduse_stall", {127'd0, stall}, 128'd1);
    drive(24'h154100, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0);
    @(negedge CLK);
    check("loaduse_bubble", {127'd0, ex_valid}, 128'd0);
    check("loaduse_stall_once", {127'd0, stall}, 128'd0);
    idle();
    @(negedge CLK);
    check("loaduse_issue_valid", {127'd0, ex_valid}, 128'd1);
    check("loaduse_issue_op", {124'd0, ex_op}, 128'd1);
    check("loaduse_issue_rd", {124'd0, ex_rd}, 128'd5);
    check("loaduse_issue_a", {104'd0, ex_a}, 128'h400);
    check("loaduse_issue_b", {104'd0, ex_b}, 128'h10);

    // Unused sources never stall: ADDI R7,R1,#0x400 and JMP with rs1=4.
    drive(24'h642000, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0);
    drive(24'h571400, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0);
    @(negedge CLK);
    check("addi_rs2_nostall", {127'd0, stall}, 128'd0);
    drive(24'h642000, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0);
    drive(24'h904000, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0);
    @(negedge CLK);
    check("jmp_nostall", {127'd0, stall}, 128'd0);

    // STORE R4,[R1]: rd is a source, so it stalls and ex_b carries R4.
    drive(24'h642000, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0);
    drive(24'h741000, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0);
    @(negedge CLK);
    check("store_stall", {127'd0, stall}, 128'd1);
    drive(24'h741000, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0);
    idle();
    @(negedge CLK);
    check("store_op", {124'd0, ex_op}, 128'd7);
    check("store_b", {104'd0, ex_b}, 128'h400);
    check("store_memwrite", {127'd0, ex_memwrite}, 128'd1);

    // Opcode 12 decodes as NOP.
    drive(24'hC12300, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0);
    idle();
    @(negedge CLK);
    check("op12_op", {124'd0, ex_op}, 128'd0);
    check("op12_ctrl", {124'd0, ex_regwrite, ex_memread, ex_memwrite, ex_branch}, 128'd0);

    // Flush with a load-use pending: no stall, ADD never issues.
    drive(24'h642000, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0);
    drive(24'h154100, 1'b1, 1'b1, 1'b0, 4'd0, 24'h0);
    @(negedge CLK);
    check("flush_nostall", {127'd0, stall}, 128'd0);
    idle();
    @(negedge CLK);
    check("flush_bubble", {127'd0, ex_valid}, 128'd0);
    idle();
    @(negedge CLK);
    check("flush_no_add", {124'd0, ex_op}, 128'd0);

    // Reset in the middle of a stall.
    drive(24'h642000, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0);
    drive(24'h154100, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0);
    @(negedge CLK);
    check("midreset_stall_before", {127'd0, stall}, 128'd1);
    #1;
    rst = 1'b0;
    #1;
    check("midreset_stall", {127'd0, stall}, 128'd0);
    check("midreset_ex", {19'd0, actual_ex}, 128'd0);
    @(posedge CLK);
    #2;
    rst = 1'b1;
    idle();
    @(negedge CLK);
    check("after_reset_issue", {127'd0, ex_valid}, 128'd1);
    check("after_reset_a", {104'd0, ex_a}, 128'd0);
    idle();
    idle();
    @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter WIDTH, default 24: instruction, PC and datapath width.
REQ-002 Parameter NREG, default 16: register-file depth; index width 4.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 instruccion  in  24  instruction word from fetch.
REQ-006 nextPc  in  24  PC+1 of that instruction, from fetch.
REQ-007 if_valid  in  1  instruccion/nextPc hold a real instruction.
REQ-008 flush  in  1  branch taken in execute; kill the instruction in decode.
REQ-009 wb_we, wb_rd, wb_data  in  1/4/24  register-file write port from writeback.
REQ-010 stall  out  1  fetch holds PC and IR this cycle.
REQ-011 ex_valid, ex_op, ex_rd  out  1/4/4  execute pipeline register: valid, opcode, destination.
REQ-012 ex_a, ex_b, ex_imm, ex_pc  out  24 each  operands, sign-extended immediate, PC+1.
REQ-013 ex_regwrite, ex_memread, ex_memwrite, ex_branch  out  1 each  control bits.

Function
REQ-014 Fields: op[23:20], rd[19:16], rs1[15:12], rs2[11:8], imm[11:0], sign-extended to 24 bits.
REQ-015 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 LOAD, 7 STORE, 8 BEQ, 9 JMP; 10-15 decode as NOP.
REQ-016 Control: regwrite for 1-6; memread for 6; memwrite for 7; branch for 8-9; STORE/BEQ read rd in place of rs2 as ex_b source.
REQ-017 Register file NREG x 24, two async read ports, one sync write port; R0 reads 0; writes to R0 ignored.
REQ-018 Write-before-read bypass: if wb_we and wb_rd equals a nonzero source index in the same cycle, that operand takes wb_data.
REQ-019 Latency: one cycle; decoded fields appear on ex_* the edge after decode with ex_valid=1.
REQ-020 Load-use hazard: ex_valid and ex_memread and ex_rd nonzero and ex_rd equals any used source of the decode instruction -> stall=1 combinationally.
REQ-021 On stall: ex_* loads a bubble (ex_valid=0, all control bits 0); the decode instruction is retained and re-decoded next cycle.
REQ-022 Stall lasts exactly one cycle per load-use pair.
REQ-023 flush has priority over stall: stall=0, ex_* loads a bubble.
REQ-024 if_valid=0: bubble into ex_*, stall=0.
REQ-025 Bubbles drive ex_op=0, ex_rd=0, data fields 0.
REQ-026 Unused sources (e.g. rs2 of ADDI, all sources of JMP/NOP) never raise stall.

Reset
REQ-027 rst=0 asynchronously clears all ex_* outputs to 0 and all registers R0..R(NREG-1) to 0.
REQ-028 stall=0 while rst=0; first valid decode occurs on the first edge after release.
REQ-029 Reset asserted mid-stall discards the held instruction; no stale output after release.

Structure
REQ-030 Opcode enum, field bit positions, WIDTH/NREG defaults live in shared package isa_pkg.
REQ-031 Register file is a separate sub-module regfile (2R1W, R0 zero, bypass inside).
REQ-032 Hazard detection and control decode are combinational inside decode_stage; only the ex_* register is sequential there.

Verification
REQ-033 Reset: rst=0 with arbitrary inputs -> all ex_*=0, stall=0; R5 reads 0 after release.
REQ-034 ADDI R1,R0,#-3 (0x510FFD) -> next cycle ex_op=5, ex_rd=1, ex_a=0, ex_imm=0xFFFFFD, ex_regwrite=1.
REQ-035 Bypass: wb_we=1, wb_rd=2, wb_data=0x00ABCD with ADD R3,R2,R2 in decode -> ex_a=ex_b=0x00ABCD.
REQ-036 Load-use: LOAD R4 in execute, ADD R5,R4,R1 in decode -> stall=1 one cycle, one bubble, then ADD issued with ex_valid=1.
REQ-037 Flush with load-use simultaneously -> stall=0, bubble issued, ADD never reaches execute.
REQ-038 Write to R0 (wb_we=1, wb_rd=0, wb_data=0x123456) then ADD R1,R0,R0 -> ex_a=ex_b=0.
